rgb_fader: RTL
==============

# rgb_fader

Parametrised RGB colour converter with timed fading. A 3-bit colour code is accepted over a valid/ready handshake. Each output channel then ramps from its current level towards full-scale or zero, by a fixed step per enabled cycle. The block sits between colour-selection logic and the LED/display driver and replaces the instantaneous code-to-RGB conversion with a parametrised, handshaked fade.

## Interface
Parameters:
- CH_W, 8, bits per colour channel; legal range 2..16.
- STEP, 1, per-cycle increment/decrement applied to each channel; legal range 1..2^CH_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, reset asynchronous and active-high.
- enable  input  1  advances the fade when high; freezes the fade when low.
- colour  input  3  colour code: bit0 = blue, bit1 = green, bit2 = red.
- colour_valid  input  1  colour code presented.
- colour_ready  output  1  block can accept a code; high only in IDLE.
- rgb  output  3*CH_W  channel levels: [CH_W-1:0] blue, [2*CH_W-1:CH_W] green, [3*CH_W-1:2*CH_W] red.
- busy  output  1  high in FADE.
- done  output  1  one-cycle pulse when a fade completes.

## Operation
- Reset values: state IDLE, rgb = 0, target = 0, done = 0, busy = 0, colour_ready = 1.
- Target per channel: all-ones (2^CH_W-1) if its colour bit is 1, else 0. Target is latched on accept.
- Accept condition: colour_valid && colour_ready on a rising edge.
  - An accepted code latches the target and moves IDLE -> FADE.
  - Accept ignores enable.
  - Codes presented while in FADE are not accepted; the source must hold them.
- FADE, on an edge with enable = 1, each channel is updated as follows:
  - level < target: level = (level > max-STEP) ? max : level+STEP.
  - level > target: level = (level < STEP) ? 0 : level-STEP.
  - level == target: level is unchanged.
  - The arithmetic is done at CH_W+1 bits; levels never wrap.
- Completion: if all three post-update levels equal target on that edge, go FADE -> IDLE and register done = 1 for exactly one cycle.
- FADE, on an edge with enable = 0: levels, state and done (0) are held.
- Accepting a code equal to the current levels still enters FADE. It completes on the first enabled edge with rgb unchanged.
- Channels move independently: a rising and a falling channel step on the same edge.
- rst asserted mid-fade: rgb clears to 0 immediately and the state returns to IDLE. No done pulse is produced.

## Timing
- colour_ready and busy are decoded combinationally from the state register.
- Accept edge N: busy = 1 and colour_ready = 0 from edge N.
- First level change happens on the first enabled edge after N.
- Full-swing fade takes ceil((2^CH_W-1)/STEP) enabled edges. The default configuration is 255 edges.
- done is registered high on the completion edge. On that same edge colour_ready returns to 1, so a new code can be accepted on the next edge; back-to-back throughput has no bubble beyond this.
- rgb is registered; there are no combinational paths from inputs to rgb.

## Configuration
- RGB_FADER_SNAP_EN:
  - Defined: on the first enabled FADE edge, every channel loads its target directly. Completion and done occur on that edge; STEP is ignored for timing.
  - Undefined: the stepped fade described above. This is the default.
  - The ports and the handshake are identical in both builds.

## Test plan
- Reset: assert rst mid-clock -> rgb = 0, colour_ready = 1, busy = 0, done = 0 immediately, with no clock edge required.
- Fade up, defaults: accept colour = 3'b111 from rgb = 0, enable held high -> done on the 255th edge after accept, rgb = 24'hFFFFFF, colour_ready = 1 on that edge.
- Mixed, CH_W = 8, STEP = 16: from 24'hFFFFFF accept 3'b010 -> red/blue step 255, 239, ..., 15, 0 and green holds at FF. done after 16 edges, rgb = 24'h00FF00.
- Enable gating: during a defaults fade, drop enable for 10 cycles -> rgb and busy frozen, done delayed by exactly 10 cycles. Holding colour_valid in FADE -> no accept until colour_ready = 1.
- Same colour and reset mid-fade: accept a code equal to the current rgb -> done after 1 enabled edge with rgb unchanged. Assert rst mid-fade -> rgb = 0 and IDLE with no done pulse.
- RGB_FADER_SNAP_EN defined: accept 3'b101 from 0 -> rgb = 24'hFF00FF and done on the first enabled edge after accept.

Source files
------------

// File: rtl/rgb_fader.sv
// Handshaked 3-bit colour code to RGB levels with a stepped fade; rgb is registered, first change one enabled edge after accept.
// colour_ready is high only while idle, so the source holds its code during a fade; RGB_FADER_SNAP_EN makes every fade a single enabled edge.
module rgb_fader #(
    parameter int CH_W = 8,
    parameter int STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [2:0]          colour,
    input  logic                colour_valid,
    output logic                colour_ready,
    output logic [3*CH_W-1:0]   rgb,
    output logic                busy,
    output logic                done
);

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0][CH_W-1:0]   lvl_q, lvl_d;
    logic [2:0][CH_W-1:0]   tgt_lvl;
    logic [2:0]             tgt_q, tgt_d;
    logic                   done_q, done_d;

`ifndef RGB_FADER_SNAP_EN
    localparam logic [CH_W:0] MAX_X  = {1'b0, {CH_W{1'b1}}};
    localparam logic [CH_W:0] STEP_X = STEP[CH_W:0];

    // One extra bit of headroom so the clamp compares never wrap.
    function automatic logic [CH_W-1:0] step_ch(input logic [CH_W-1:0] lvl,
                                                input logic [CH_W-1:0] tgt);
        logic [CH_W:0] l, t, r;
        l = {1'b0, lvl};
        t = {1'b0, tgt};
        r = l;
        if (l < t)
            r = (l > MAX_X - STEP_X) ? MAX_X : l + STEP_X;
        else if (l > t)
            r = (l < STEP_X) ? '0 : l - STEP_X;
        return r[CH_W-1:0];
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < 3; i++)
            tgt_lvl[i] = {CH_W{tgt_q[i]}};
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (colour_valid) begin
                    tgt_d   = colour;
                    state_d = FADE;
                end
            end
            FADE: begin
                if (enable) begin
`ifdef RGB_FADER_SNAP_EN
                    lvl_d = tgt_lvl;
`else
                    for (int i = 0; i < 3; i++)
                        lvl_d[i] = step_ch(lvl_q[i], tgt_lvl[i]);
`endif
                    if (lvl_d == tgt_lvl) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign colour_ready = (state_q == IDLE);
    assign busy         = (state_q == FADE);
    assign rgb          = lvl_q;
    assign done         = done_q;

endmodule
